// File: rtl/pincel_pkg.sv
// pincel_pkg: shared constants, FSM states and coordinate type for pincel_tracker
package pincel_pkg;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   typedef logic [10:0] coord_t;
   typedef enum logic [2:0] {IDLE, DIVIDE, FILTER, MISS, OUT} state_t;
endpackage

// File: rtl/pincel_tracker_if.sv
// pincel_tracker_if: detector inputs and cursor outputs of pincel_tracker
interface pincel_tracker_if #(parameter int IDX_W = 20, parameter int COORD_W = 11);
   logic               vsync;
   logic [IDX_W-1:0]   detect_pos;
   logic               achou;
   logic [COORD_W-1:0] x_out;
   logic [COORD_W-1:0] y_out;
   logic               pos_valid;
   logic               pincel_ativo;
   modport master (output vsync, detect_pos, achou, input x_out, y_out, pos_valid, pincel_ativo);
   modport slave (input vsync, detect_pos, achou, output x_out, y_out, pos_valid, pincel_ativo);
endinterface

// File: rtl/seq_div_const.sv
// seq_div_const: start/done restoring divider, one quotient bit per cycle over W cycles
module seq_div_const #(
   parameter int W     = 20,
   parameter int OUT_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [W-1:0]     dividend,
   input  logic [W-1:0]     divisor,
   output logic [OUT_W-1:0] quotient,
   output logic [OUT_W-1:0] remainder,
   output logic             done
);
   localparam int CW = $clog2(W + 1);
   logic [W-1:0]  q_q, q_d;
   logic [W:0]    r_q, r_d, trial;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fit;
   always_comb begin
      trial = (r_q << 1) | (W+1)'(q_q[W-1]);
      fit = trial >= {1'b0, divisor};
      done = cnt_q == CW'(1);
      q_d = q_q;
      r_d = r_q;
      cnt_d = cnt_q;
      if (start) begin
         q_d = dividend;
         r_d = '0;
         cnt_d = CW'(W);
      end else if (cnt_q != '0) begin
         r_d = fit ? trial - {1'b0, divisor} : trial;
         q_d = {q_q[W-2:0], fit};
         cnt_d = cnt_q - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
         r_q <= '0;
         cnt_q <= '0;
      end else begin
         q_q <= q_d;
         r_q <= r_d;
         cnt_q <= cnt_d;
      end
   end
   assign quotient = q_q[OUT_W-1:0];
   assign remainder = r_q[OUT_W-1:0];
endmodule

// File: rtl/pincel_tracker.sv
// pincel_tracker: per-frame spot index -> filtered, debounced cursor; PINCEL_TRACKER_DEADZONE_EN holds small moves
module pincel_tracker import pincel_pkg::*; #(
   parameter int H_RES       = H_RES_DEF,
   parameter int V_RES       = V_RES_DEF,
   parameter int IDX_W       = 20,
   parameter int COORD_W     = 11,
   parameter int ALPHA_SHIFT = 2,
   parameter int MISS_LIMIT  = 4,
   parameter int DEADZONE    = 3
) (
   input logic             clk,
   input logic             reset,
   pincel_tracker_if.slave bus
);
   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam logic [IDX_W-1:0] N_PIX = IDX_W'(H_RES * V_RES);
   localparam logic signed [COORD_W:0] DZ = (COORD_W+1)'(DEADZONE);
`ifdef PINCEL_TRACKER_DEADZONE_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif
   state_t                    state_q, state_d;
   logic [2:0]                vs_q, vs_d;
   logic [1:0]                ac_q, ac_d;
   logic [COORD_W-1:0]        x_f_q, x_f_d, y_f_q, y_f_d, x_out_q, x_out_d, y_out_q, y_out_d;
   logic [COORD_W-1:0]        x_new, y_new;
   logic [MW-1:0]             miss_q, miss_d;
   logic                      first_q, first_d, act_q, act_d, pv_q, pv_d;
   logic                      trig, start, done, in_dz;
   logic signed [COORD_W:0]   dx, dy;
   seq_div_const #(.W(IDX_W), .OUT_W(COORD_W)) u_div (
      .clk(clk), .reset(reset), .start(start), .dividend(bus.detect_pos),
      .divisor(IDX_W'(H_RES)), .quotient(y_new), .remainder(x_new), .done(done)
   );
   always_comb begin
      vs_d = {vs_q[1:0], bus.vsync};
      ac_d = {ac_q[0], bus.achou};
      trig = vs_q[1] & ~vs_q[2];
      dx = $signed({1'b0, x_new}) - $signed({1'b0, x_f_q});
      dy = $signed({1'b0, y_new}) - $signed({1'b0, y_f_q});
      in_dz = DZ_EN && (dx[COORD_W] ? -dx : dx) <= DZ && (dy[COORD_W] ? -dy : dy) <= DZ;
      state_d = state_q;
      start = 1'b0;
      first_d = first_q;
      act_d = act_q;
      miss_d = miss_q;
      x_f_d = x_f_q;
      y_f_d = y_f_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      pv_d = 1'b0;
      case (state_q)
         IDLE: if (trig) begin
            start = ac_q[1] && bus.detect_pos < N_PIX;
            state_d = start ? DIVIDE : MISS;
         end
         DIVIDE: state_d = done ? FILTER : DIVIDE;
         FILTER: begin
            x_f_d = first_q ? x_new : in_dz ? x_f_q : x_f_q + COORD_W'(dx >>> ALPHA_SHIFT);
            y_f_d = first_q ? y_new : in_dz ? y_f_q : y_f_q + COORD_W'(dy >>> ALPHA_SHIFT);
            first_d = 1'b0;
            miss_d = '0;
            act_d = 1'b1;
            state_d = OUT;
         end
         MISS: begin
            miss_d = miss_q < MW'(MISS_LIMIT) ? miss_q + 1'b1 : miss_q;
            act_d = miss_d == MW'(MISS_LIMIT) ? 1'b0 : act_q;
            first_d = miss_d == MW'(MISS_LIMIT) ? 1'b1 : first_q;
            state_d = IDLE;
         end
         OUT: begin
            x_out_d = x_f_q;
            y_out_d = y_f_q;
            pv_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         vs_q <= '0;
         ac_q <= '0;
         x_f_q <= '0;
         y_f_q <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         miss_q <= '0;
         first_q <= 1'b1;
         act_q <= 1'b0;
         pv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vs_q <= vs_d;
         ac_q <= ac_d;
         x_f_q <= x_f_d;
         y_f_q <= y_f_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         miss_q <= miss_d;
         first_q <= first_d;
         act_q <= act_d;
         pv_q <= pv_d;
      end
   end
   assign bus.x_out = x_out_q;
   assign bus.y_out = y_out_q;
   assign bus.pos_valid = pv_q;
   assign bus.pincel_ativo = act_q;
endmodule

// File: tb/tb_pincel_tracker.sv
// tb_pincel_tracker: directed and random frames against a frame-level cursor model
module tb_pincel_tracker;
   localparam int H = 640, V = 480, LIM = 4, GAIN = 4, DZV = 3;
`ifdef PINCEL_TRACKER_DEADZONE_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0, miscompares = 0;
   int m_fx, m_fy, m_x, m_y, m_miss;
   bit m_first, m_act;
   pincel_tracker_if bus ();
   pincel_tracker dut (.clk(clk), .reset(reset), .bus(bus));
   always #10 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic int fdiv(input int d);
      return d >= 0 ? d / GAIN : -((-d + GAIN - 1) / GAIN);
   endfunction
   function automatic int iabs(input int d);
      return d < 0 ? -d : d;
   endfunction
   task automatic model_reset();
      m_fx = 0; m_fy = 0; m_x = 0; m_y = 0; m_miss = 0; m_first = 1'b1; m_act = 1'b0;
   endtask
   task automatic model_frame(input bit ac, input int pos, output bit hit);
      int nx, ny;
      hit = ac && pos < H * V;
      if (hit) begin
         nx = pos % H;
         ny = pos / H;
         if (m_first) begin
            m_fx = nx; m_fy = ny;
         end else if (!(DZ && iabs(nx - m_fx) <= DZV && iabs(ny - m_fy) <= DZV)) begin
            m_fx = m_fx + fdiv(nx - m_fx);
            m_fy = m_fy + fdiv(ny - m_fy);
         end
         m_first = 1'b0; m_miss = 0; m_act = 1'b1; m_x = m_fx; m_y = m_fy;
      end else begin
         if (m_miss < LIM) m_miss++;
         if (m_miss == LIM) begin m_act = 1'b0; m_first = 1'b1; end
      end
   endtask
   // rst_at >= 0 pulses reset that many clocks after vsync rises (13 = 10 clocks into the divide)
   task automatic run_frame(input bit ac, input int pos, input int rst_at);
      int first_n, pulses;
      bit hit;
      bus.achou = ac;
      bus.detect_pos = 20'(pos);
      repeat (4) @(negedge clk);
      bus.vsync = 1'b1;
      first_n = 0;
      pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 4) bus.vsync = 1'b0;
         if (n == rst_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("rst_x", bus.x_out, 0);
            check("rst_y", bus.y_out, 0);
            check("rst_pv", bus.pos_valid, 0);
            check("rst_ativo", bus.pincel_ativo, 0);
            model_reset();
         end
         if (bus.pos_valid) begin
            pulses++;
            if (first_n == 0) first_n = n;
         end
      end
      hit = 1'b0;
      if (rst_at < 0) model_frame(ac, pos, hit);
      check("pulses", pulses, hit ? 1 : 0);
      if (hit) check("latency", first_n, 25);
      check("x_out", bus.x_out, m_x);
      check("y_out", bus.y_out, m_y);
      check("ativo", bus.pincel_ativo, m_act);
   endtask
   initial begin
      bus.vsync = 1'b0;
      bus.achou = 1'b0;
      bus.detect_pos = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_x", bus.x_out, 0);
      check("reset_y", bus.y_out, 0);
      check("reset_pv", bus.pos_valid, 0);
      check("reset_ativo", bus.pincel_ativo, 0);
      run_frame(1'b1, 1283, -1);
      check("first_x", bus.x_out, 3);
      check("first_y", bus.y_out, 2);
      run_frame(1'b1, 2 * H + 103, -1);
      check("filt_x", bus.x_out, 28);
      check("filt_y", bus.y_out, 2);
      repeat (4) run_frame(1'b0, 1283, -1);
      check("lost_ativo", bus.pincel_ativo, 0);
      run_frame(1'b1, 100 * H + 200, -1);
      check("reload_x", bus.x_out, 200);
      check("reload_y", bus.y_out, 100);
      run_frame(1'b1, H * V, -1);
      check("oor_ativo", bus.pincel_ativo, 1);
      repeat (3) run_frame(1'b0, 5, -1);
      check("oor_lost", bus.pincel_ativo, 0);
      run_frame(1'b1, 50 * H + 60, 13);
      run_frame(1'b1, 50 * H + 60, -1);
      check("after_rst_x", bus.x_out, 60);
      check("after_rst_y", bus.y_out, 50);
`ifdef PINCEL_TRACKER_DEADZONE_EN
      repeat (4) run_frame(1'b0, 0, -1);
      run_frame(1'b1, 100 * H + 100, -1);
      run_frame(1'b1, 101 * H + 102, -1);
      check("dz_x", bus.x_out, 100);
      check("dz_y", bus.y_out, 100);
`endif
      for (int i = 0; i < 25; i++)
         run_frame($urandom_range(0, 4) != 0,
                   $urandom_range(0, 7) == 0 ? int'($urandom_range(H * V, 1048575)) : int'($urandom_range(0, H * V - 1)),
                   -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
